seg7_display_sched: RTL and testbench
=====================================

Name: seg7_display_sched

Overview:
- Time-shares the 8-digit 7-segment display between up to NSRC 32-bit data sources, e.g. mtime, core PC, core IR and checksum.
- Round-robins among requesting sources with a programmable dwell time.
- Lets one priority source pre-empt the rotation, and supports a manual lock onto one source.
- Sits between the SoC status wires and the 7-seg controller; drives its 32-bit data input and blank control.

Parameters:
- NSRC, 4: number of sources. Fixed at 4 for this revision; o_src and i_sel are 2 bits.
- DWELL, 64000000: cycles each source is shown before rotating (1 s at 64 MHz). Minimum 2.
- PRI_SRC, 0: index of the pre-empting source.

Ports:
- CLK  in  1  core clock.
- RST  in  1  synchronous, active-high reset.
- i_req  in  NSRC  per-source "wants display" level.
- i_data  in  32*NSRC  source k occupies bits [32k+31:32k].
- i_next  in  1  one-cycle pulse: advance rotation now.
- i_sel_valid  in  1  manual lock request.
- i_sel  in  2  source index to lock onto; sampled when i_sel_valid=1.
- i_sel_release  in  1  leave manual lock.
- o_data  out  32  registered display word.
- o_src  out  2  index of the source currently shown.
- o_blank  out  1  1 = nothing to show.
- o_switch  out  1  one-cycle pulse when o_src changes or display leaves blank.
- o_hold  out  1  1 while in manual lock.

Behaviour:
- Reset (RST=1 at a clock edge), regardless of the current state:
  - state=IDLE, rr_ptr=0, dwell_cnt=0, saved_ptr=0;
  - o_data=0, o_src=0, o_blank=1, o_switch=0, o_hold=0.
- Latency: o_data = registered i_data of the selected source, one cycle behind, updated every cycle (live value, not a snapshot).
- States:
  - IDLE: no requester. o_blank=1, o_data=0.
    - Any i_req bit set → SHOW, with source = first requester at or after rr_ptr (cyclic); o_switch=1; dwell_cnt=0.
  - SHOW: dwell_cnt increments each cycle.
    - dwell_cnt==DWELL-1 or i_next=1: select the next requester strictly after the current index (cyclic); dwell_cnt=0; rr_ptr=new index.
    - If the only requester is the current source, keep it, reset dwell_cnt, and do not pulse o_switch.
    - Current source drops i_req: switch to the next requester the following edge, or go to IDLE (o_switch=0) if there is none.
  - PREEMPT: entered from IDLE or SHOW when i_req[PRI_SRC]=1, o_src!=PRI_SRC and the lock is not active. saved_ptr=current rr_ptr.
    - Shows PRI_SRC; dwell_cnt and i_next are ignored.
    - On i_req[PRI_SRC]=0: resume the SHOW search from saved_ptr, or IDLE if no requester.
    - If PRI_SRC is already shown in SHOW, stay in SHOW; normal rotation applies.
  - HOLD: entered from any state on i_sel_valid. Shows i_sel even if its i_req=0 (o_blank=0); o_hold=1.
    - i_sel_valid in HOLD with a different i_sel changes source, o_switch=1.
    - i_sel_release → re-evaluate as from IDLE in the same edge.
- Event priority within one cycle: RST > i_sel_valid > i_sel_release > pre-empt > current-source drop > dwell expiry / i_next.
  - i_sel_valid and i_sel_release together: the lock is taken or updated; release is ignored.
- dwell_cnt width is $clog2(DWELL). dwell_cnt saturates only by wrapping to 0 on expiry; no overflow path.
- o_switch is asserted exactly on the edge where o_src or o_blank changes to a new visible source; never two consecutive cycles for one change.
- All outputs are registered; no combinational input-to-output path.

Decomposition:
- Shared package holds:
  - state encoding ST_IDLE / ST_SHOW / ST_PREEMPT / ST_HOLD (2 bits);
  - SRC_MTIME=0, SRC_PC=1, SRC_IR=2, SRC_CSUM=3;
  - NSRC=4.
- One combinational sub-module, seg7_rr_pick:
  - inputs: req[3:0], start[1:0], inclusive flag;
  - outputs: found, idx[1:0];
  - used for the IDLE, rotation and resume searches.

Test Plan (DWELL=8, PRI_SRC=0 unless stated):
- Reset then i_req=0 → o_blank=1, o_data=0, o_switch=0 for 20 cycles.
- i_req=4'b1110, data1=0x11111111, data2=0x22222222, data3=0x33333333 → o_src 1→2→3→1, each held 8 cycles; o_switch pulses once at each change; o_data tracks the live source value with 1-cycle lag.
- i_req=4'b0100, with i_next pulsed mid-dwell → o_src stays 2, no o_switch, dwell restarts.
- Rotating on src 2 (i_req=4'b1110), raise i_req[0] → next edge o_src=0, held past 8 cycles. Drop i_req[0] → o_src=3 (resume after the saved pointer).
- i_sel_valid=1, i_sel=3, with i_req=4'b0000 → o_src=3, o_hold=1, o_blank=0, o_data=data3. Raising i_req[0] has no effect. i_sel_release → o_src=0, o_hold=0.
- Assert RST mid-PREEMPT and mid-HOLD → all outputs return to reset values next edge. Same-cycle i_sel_valid + i_sel_release → HOLD taken.

Source files
------------

// File: rtl/seg7_display_sched_pkg.sv
// ---------------------------------------------------------------------------
// seg7_display_sched_pkg
// Shared definitions for the 7-segment display scheduler:
//   - number of sources and source index width
//   - scheduler state encoding
//   - symbolic indices of the SoC status sources
//   - src_add: modulo-NSRC addition of two source indices
// ---------------------------------------------------------------------------
package seg7_display_sched_pkg;

   localparam int unsigned NSRC  = 4;
   localparam int unsigned SRC_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SHOW    = 2'd1,
      ST_PREEMPT = 2'd2,
      ST_HOLD    = 2'd3
   } state_e;

   localparam logic [SRC_W-1:0] SRC_MTIME = 2'd0;
   localparam logic [SRC_W-1:0] SRC_PC    = 2'd1;
   localparam logic [SRC_W-1:0] SRC_IR    = 2'd2;
   localparam logic [SRC_W-1:0] SRC_CSUM  = 2'd3;

   // Source indices wrap naturally because NSRC equals 2**SRC_W.
   function automatic logic [SRC_W-1:0] src_add(input logic [SRC_W-1:0] a,
                                                input logic [SRC_W-1:0] b);
      return a + b;
   endfunction

endpackage

// File: rtl/seg7_rr_pick.sv
// ---------------------------------------------------------------------------
// seg7_rr_pick
// Combinational cyclic search for the first requesting source.
//   req_i       : per-source request levels
//   start_i     : index the search is anchored on
//   inclusive_i : 1 = start_i itself is the first candidate,
//                 0 = start at start_i+1; start_i is then the last candidate
//   found_o     : at least one request bit set
//   idx_o       : index of the first requester in search order
// ---------------------------------------------------------------------------
module seg7_rr_pick
   import seg7_display_sched_pkg::*;
(
   input  logic [NSRC-1:0]  req_i,
   input  logic [SRC_W-1:0] start_i,
   input  logic             inclusive_i,
   output logic             found_o,
   output logic [SRC_W-1:0] idx_o
);

   logic [SRC_W-1:0] first_s;
   logic [NSRC-1:0]  rot_s;
   logic [SRC_W-1:0] off_s;

   assign first_s = inclusive_i ? start_i : src_add(start_i, 2'd1);

   // Rotate the request vector so that bit 0 is the first candidate.
   always_comb begin
      rot_s = 4'b0000;
      for (int k = 0; k < NSRC; k++) begin
         rot_s[k] = req_i[src_add(first_s, 2'(k))];
      end
   end

   // Priority-encode the rotated vector; lowest set bit wins.
   always_comb begin
      found_o = 1'b1;
      off_s   = 2'd0;
      casez (rot_s)
         4'b???1: off_s = 2'd0;
         4'b??10: off_s = 2'd1;
         4'b?100: off_s = 2'd2;
         4'b1000: off_s = 2'd3;
         default: found_o = 1'b0;
      endcase
   end

   assign idx_o = src_add(first_s, off_s);

endmodule

// File: rtl/seg7_display_sched.sv
// ---------------------------------------------------------------------------
// seg7_display_sched
// Time-shares the 8-digit 7-segment display between NSRC 32-bit sources.
// Requesting sources are rotated with a programmable dwell time, one
// priority source can pre-empt the rotation, and a manual lock can pin the
// display onto any source.
//   CLK, RST      : clock, synchronous active-high reset
//   i_req         : per-source "wants display" level
//   i_data        : source k on bits [32k+31:32k]
//   i_next        : one-cycle pulse, advance the rotation now
//   i_sel_valid   : manual lock request onto i_sel
//   i_sel         : source to lock onto
//   i_sel_release : leave the manual lock
//   o_data        : registered live word of the shown source (0 when blank)
//   o_src         : index of the shown source
//   o_blank       : nothing to show
//   o_switch      : one-cycle pulse when a new source becomes visible
//   o_hold        : manual lock active
// ---------------------------------------------------------------------------
module seg7_display_sched
   import seg7_display_sched_pkg::*;
#(
   parameter int unsigned DWELL   = 64000000,
   parameter int unsigned PRI_SRC = 0
)
(
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [NSRC-1:0]      i_req,
   input  logic [32*NSRC-1:0]   i_data,
   input  logic                 i_next,
   input  logic                 i_sel_valid,
   input  logic [SRC_W-1:0]     i_sel,
   input  logic                 i_sel_release,
   output logic [31:0]          o_data,
   output logic [SRC_W-1:0]     o_src,
   output logic                 o_blank,
   output logic                 o_switch,
   output logic                 o_hold
);

   localparam int unsigned      DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
   localparam logic [SRC_W-1:0] PRI_IDX    = SRC_W'(PRI_SRC);

   state_e           state_q,     state_d;
   logic [SRC_W-1:0] rr_ptr_q,    rr_ptr_d;
   logic [SRC_W-1:0] saved_ptr_q, saved_ptr_d;
   logic [DW_W-1:0]  dwell_cnt_q, dwell_cnt_d;
   logic [SRC_W-1:0] src_q,       src_d;
   logic             blank_q,     blank_d;
   logic             hold_q,      hold_d;
   logic             switch_q,    switch_d;
   logic [31:0]      data_q,      data_d;

   logic [31:0]      data_arr_s [NSRC];
   logic [SRC_W-1:0] pick_start_s;
   logic             pick_incl_s;
   logic             pick_found_s;
   logic [SRC_W-1:0] pick_idx_s;
   logic             pre_ok_s;

   for (genvar g = 0; g < NSRC; g++) begin : g_data
      assign data_arr_s[g] = i_data[32*g +: 32];
   end

   // Anchor of the shared search: rotation/drop searches after the shown
   // source, resume searches after the saved pointer, and IDLE-style
   // evaluation (also used on lock release) searches from rr_ptr inclusive.
   always_comb begin
      pick_start_s = rr_ptr_q;
      pick_incl_s  = 1'b1;
      case (state_q)
         ST_SHOW: begin
            pick_start_s = src_q;
            pick_incl_s  = 1'b0;
         end
         ST_PREEMPT: begin
            pick_start_s = saved_ptr_q;
            pick_incl_s  = 1'b0;
         end
         default: begin
            pick_start_s = rr_ptr_q;
            pick_incl_s  = 1'b1;
         end
      endcase
   end

   seg7_rr_pick u_pick (
      .req_i       (i_req),
      .start_i     (pick_start_s),
      .inclusive_i (pick_incl_s),
      .found_o     (pick_found_s),
      .idx_o       (pick_idx_s)
   );

   // Pre-emption is only meaningful when the priority source is not
   // already the visible one.
   assign pre_ok_s = i_req[PRI_IDX] && (blank_q || (src_q != PRI_IDX));

   // Next-state evaluation in event priority order.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      saved_ptr_d = saved_ptr_q;
      dwell_cnt_d = dwell_cnt_q;
      src_d       = src_q;
      blank_d     = blank_q;
      hold_d      = 1'b0;

      if (i_sel_valid) begin
         // Lock taken or moved; a simultaneous release is ignored.
         state_d     = ST_HOLD;
         src_d       = i_sel;
         blank_d     = 1'b0;
         hold_d      = 1'b1;
         dwell_cnt_d = DW_W'(0);
      end else if ((state_q == ST_HOLD) && !i_sel_release) begin
         hold_d = 1'b1;
      end else if ((state_q != ST_PREEMPT) && pre_ok_s) begin
         state_d     = ST_PREEMPT;
         saved_ptr_d = rr_ptr_q;
         src_d       = PRI_IDX;
         blank_d     = 1'b0;
         dwell_cnt_d = DW_W'(0);
      end else if (state_q == ST_PREEMPT) begin
         if (!i_req[PRI_IDX]) begin
            dwell_cnt_d = DW_W'(0);
            if (pick_found_s) begin
               state_d  = ST_SHOW;
               src_d    = pick_idx_s;
               rr_ptr_d = pick_idx_s;
               blank_d  = 1'b0;
            end else begin
               state_d = ST_IDLE;
               blank_d = 1'b1;
            end
         end else begin
            state_d = ST_PREEMPT;
         end
      end else if (state_q == ST_SHOW) begin
         if (!i_req[src_q]) begin
            dwell_cnt_d = DW_W'(0);
            if (pick_found_s) begin
               src_d    = pick_idx_s;
               rr_ptr_d = pick_idx_s;
            end else begin
               state_d = ST_IDLE;
               blank_d = 1'b1;
            end
         end else if ((dwell_cnt_q == DWELL_LAST) || i_next) begin
            // The current source is still requesting, so the search always
            // finds something; it returns src_q when it is the only one.
            dwell_cnt_d = DW_W'(0);
            src_d       = pick_idx_s;
            rr_ptr_d    = pick_idx_s;
         end else begin
            dwell_cnt_d = dwell_cnt_q + DW_W'(1);
         end
      end else begin
         // IDLE, or lock release re-evaluated as from IDLE.
         dwell_cnt_d = DW_W'(0);
         if (pick_found_s) begin
            state_d  = ST_SHOW;
            src_d    = pick_idx_s;
            rr_ptr_d = pick_idx_s;
            blank_d  = 1'b0;
         end else begin
            state_d = ST_IDLE;
            blank_d = 1'b1;
         end
      end
   end

   // Output word and switch pulse follow from the next visible source.
   always_comb begin
      switch_d = !blank_d && (blank_q || (src_d != src_q));
      if (blank_d) begin
         data_d = 32'h0000_0000;
      end else begin
         data_d = data_arr_s[src_d];
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= 2'd0;
         saved_ptr_q <= 2'd0;
         dwell_cnt_q <= DW_W'(0);
         src_q       <= 2'd0;
         blank_q     <= 1'b1;
         hold_q      <= 1'b0;
         switch_q    <= 1'b0;
         data_q      <= 32'h0000_0000;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         saved_ptr_q <= saved_ptr_d;
         dwell_cnt_q <= dwell_cnt_d;
         src_q       <= src_d;
         blank_q     <= blank_d;
         hold_q      <= hold_d;
         switch_q    <= switch_d;
         data_q      <= data_d;
      end
   end

   assign o_data   = data_q;
   assign o_src    = src_q;
   assign o_blank  = blank_q;
   assign o_switch = switch_q;
   assign o_hold   = hold_q;

endmodule

// File: tb/tb_seg7_display_sched.sv
module tb_seg7_display_sched;

   localparam int DW  = 8;
   localparam int PRI = 0;

   localparam int M_IDLE = 0;
   localparam int M_SHOW = 1;
   localparam int M_PRE  = 2;
   localparam int M_HOLD = 3;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic [3:0]   i_req = 4'b0000;
   logic [127:0] i_data = 128'h0;
   logic         i_next = 1'b0;
   logic         i_sel_valid = 1'b0;
   logic [1:0]   i_sel = 2'd0;
   logic         i_sel_release = 1'b0;
   logic [31:0]  o_data;
   logic [1:0]   o_src;
   logic         o_blank;
   logic         o_switch;
   logic         o_hold;

   always #5 CLK = ~CLK;

   seg7_display_sched #(.DWELL(DW), .PRI_SRC(PRI)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .i_req         (i_req),
      .i_data        (i_data),
      .i_next        (i_next),
      .i_sel_valid   (i_sel_valid),
      .i_sel         (i_sel),
      .i_sel_release (i_sel_release),
      .o_data        (o_data),
      .o_src         (o_src),
      .o_blank       (o_blank),
      .o_switch      (o_switch),
      .o_hold        (o_hold)
   );

   typedef struct {
      logic        blank;
      logic        sw;
      logic        hold;
      logic [1:0]  src;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] dw [4];
   bit          rand_all = 1'b0;

   // Reference state: what the display should be doing, in plain terms.
   int m_mode  = M_IDLE;
   int m_cur   = 0;
   int m_ptr   = 0;
   int m_saved = 0;
   int m_cnt   = 0;
   bit m_blank = 1'b1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // First requester going round the ring from 'from'; with incl=0 the
   // search starts one past 'from' and visits 'from' last.
   function automatic int find_req(input logic [3:0] r, input int from, input bit incl);
      int first;
      first = incl ? 0 : 1;
      for (int n = first; n < first + 4; n++) begin
         if (r[(from + n) % 4]) return (from + n) % 4;
      end
      return -1;
   endfunction

   function automatic void go_to(input int c);
      m_cnt = 0;
      if (c < 0) begin
         m_mode  = M_IDLE;
         m_blank = 1'b1;
      end else begin
         m_mode  = M_SHOW;
         m_cur   = c;
         m_ptr   = c;
         m_blank = 1'b0;
      end
   endfunction

   function automatic void model_step(input bit rst, input logic [3:0] r, input bit nxt,
                                      input bit selv, input int sel, input bit rel);
      if (rst) begin
         m_mode = M_IDLE; m_ptr = 0; m_saved = 0; m_cnt = 0; m_cur = 0; m_blank = 1'b1;
      end else if (selv) begin
         m_mode = M_HOLD; m_cur = sel; m_blank = 1'b0; m_cnt = 0;
      end else if (m_mode == M_HOLD && !rel) begin
         m_mode = M_HOLD;
      end else if (m_mode != M_PRE && r[PRI] && !(!m_blank && m_cur == PRI)) begin
         m_saved = m_ptr; m_mode = M_PRE; m_cur = PRI; m_blank = 1'b0; m_cnt = 0;
      end else if (m_mode == M_PRE) begin
         if (!r[PRI]) go_to(find_req(r, m_saved, 1'b0));
      end else if (m_mode == M_SHOW) begin
         if (!r[m_cur]) begin
            go_to(find_req(r, m_cur, 1'b0));
         end else if (m_cnt == DW - 1 || nxt) begin
            go_to(find_req(r, m_cur, 1'b0));
         end else begin
            m_cnt++;
         end
      end else begin
         go_to(find_req(r, m_ptr, 1'b1));
      end
   endfunction

   task automatic tick(input bit rst_v, input logic [3:0] req_v, input bit nxt_v,
                       input bit selv_v, input logic [1:0] sel_v, input bit rel_v);
      exp_t e;
      bit   prev_vis;
      int   prev_cur;
      @(negedge CLK);
      dw[0] = $urandom();
      if (rand_all) begin
         for (int k = 1; k < 4; k++) dw[k] = $urandom();
      end
      RST           = rst_v;
      i_req         = req_v;
      i_next        = nxt_v;
      i_sel_valid   = selv_v;
      i_sel         = sel_v;
      i_sel_release = rel_v;
      i_data        = {dw[3], dw[2], dw[1], dw[0]};
      prev_vis = !m_blank;
      prev_cur = m_cur;
      model_step(rst_v, req_v, nxt_v, selv_v, int'(sel_v), rel_v);
      e.blank = m_blank;
      e.src   = 2'(m_cur);
      e.data  = m_blank ? 32'h0 : dw[m_cur];
      e.sw    = !m_blank && (!prev_vis || m_cur != prev_cur);
      e.hold  = (m_mode == M_HOLD);
      exp_q.push_back(e);
   endtask

   task automatic settle();
      @(posedge CLK);
      #1;
   endtask

   // Monitor: one expected entry per clock edge once stimulus is running.
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("blank", {31'h0, o_blank}, {31'h0, e.blank});
            chk("switch", {31'h0, o_switch}, {31'h0, e.sw});
            chk("hold", {31'h0, o_hold}, {31'h0, e.hold});
            chk("data", o_data, e.data);
            if (!e.blank) chk("src", {30'h0, o_src}, {30'h0, e.src});
         end
      end
   end

   initial begin
      logic [3:0] rq;
      dw[0] = 32'h0; dw[1] = 32'h1111_1111; dw[2] = 32'h2222_2222; dw[3] = 32'h3333_3333;

      // Reset, then nothing requesting.
      tick(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
      tick(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
      settle();
      chk("rst_blank", {31'h0, o_blank}, 32'd1);
      chk("rst_src", {30'h0, o_src}, 32'd0);
      chk("rst_data", o_data, 32'h0);
      repeat (20) tick(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

      // Plain rotation over sources 1..3.
      repeat (30) tick(1'b0, 4'b1110, 1'b0, 1'b0, 2'd0, 1'b0);

      // Single requester with an i_next pulse mid-dwell.
      repeat (3) tick(1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 1'b0);
      tick(1'b0, 4'b0100, 1'b1, 1'b0, 2'd0, 1'b0);
      settle();
      chk("next_single_src", {30'h0, o_src}, 32'd2);
      chk("next_single_sw", {31'h0, o_switch}, 32'd0);
      repeat (10) tick(1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 1'b0);

      // Pre-emption by source 0 while showing source 2, then resume.
      tick(1'b0, 4'b1110, 1'b0, 1'b0, 2'd0, 1'b0);
      repeat (12) tick(1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);
      settle();
      chk("preempt_src", {30'h0, o_src}, 32'd0);
      tick(1'b0, 4'b1110, 1'b0, 1'b0, 2'd0, 1'b0);
      settle();
      chk("resume_src", {30'h0, o_src}, 32'd3);

      // Manual lock on a non-requesting source.
      tick(1'b0, 4'b0000, 1'b0, 1'b1, 2'd3, 1'b0);
      settle();
      chk("hold_src", {30'h0, o_src}, 32'd3);
      chk("hold_flag", {31'h0, o_hold}, 32'd1);
      chk("hold_data", o_data, 32'h3333_3333);
      repeat (5) tick(1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0);
      tick(1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b1);
      settle();
      chk("release_src", {30'h0, o_src}, 32'd0);
      chk("release_hold", {31'h0, o_hold}, 32'd0);

      // Reset in the middle of pre-emption and of a lock.
      repeat (4) tick(1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0);
      tick(1'b1, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0);
      settle();
      chk("rst_pre_blank", {31'h0, o_blank}, 32'd1);
      tick(1'b0, 4'b0110, 1'b0, 1'b1, 2'd2, 1'b0);
      repeat (3) tick(1'b0, 4'b0110, 1'b0, 1'b0, 2'd0, 1'b0);
      tick(1'b1, 4'b0110, 1'b0, 1'b0, 2'd0, 1'b0);
      settle();
      chk("rst_hold_hold", {31'h0, o_hold}, 32'd0);

      // Lock and release in the same cycle: lock wins.
      tick(1'b0, 4'b0110, 1'b0, 1'b1, 2'd1, 1'b1);
      settle();
      chk("selv_rel_hold", {31'h0, o_hold}, 32'd1);
      chk("selv_rel_src", {30'h0, o_src}, 32'd1);
      tick(1'b0, 4'b0110, 1'b0, 1'b0, 2'd0, 1'b1);

      // Random traffic with live data on every source.
      rand_all = 1'b1;
      rq = 4'b0000;
      for (int i = 0; i < 900; i++) begin
         if ($urandom_range(0, 5) == 0) rq = 4'($urandom_range(0, 15));
         tick(($urandom_range(0, 299) == 0), rq, ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 19) == 0));
      end

      repeat (3) @(posedge CLK);
      #2;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
